// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the Beta register file slice.
// R31 reads as zero and is never stored or tracked.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = 5'd31;
  localparam logic [DATA_W-1:0] DATA_ZERO = 32'h0000_0000;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (addr == ZERO_ADDR);
  endfunction

  function automatic logic addr_hit(input logic en,
                                    input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] target);
    return en && (addr == target) && !is_zero_reg(target);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating counter per real register,
// sticky overflow flag, and the busy indication for both read ports.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter bit BYPASS  = 1'b1,
  parameter int SB_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] rf_w_addr,
  input  logic              rf_we,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              ra_busy,
  output logic              rb_busy,
  output logic              sb_overflow
);

  localparam logic [SB_BITS-1:0] CNT_ZERO = {SB_BITS{1'b0}};
  localparam logic [SB_BITS-1:0] CNT_MAX  = {SB_BITS{1'b1}};
  localparam logic [SB_BITS-1:0] CNT_ONE  = SB_BITS'(1);

  logic [SB_BITS-1:0] count_r      [0:ZERO_REG-1];
  logic [SB_BITS-1:0] count_nxt_s  [0:ZERO_REG-1];
  logic [SB_BITS-1:0] count_view_s [0:NUM_REGS-1];
  logic               inc_s        [0:ZERO_REG-1];
  logic               dec_s        [0:ZERO_REG-1];
  logic               ovf_hit_s;
  logic               ovf_r;
  logic [SB_BITS-1:0] ra_cnt_s;
  logic [SB_BITS-1:0] rb_cnt_s;

  // A retire only counts against a register that actually has something pending.
  always_comb begin
    ovf_hit_s = 1'b0;
    for (int r = 0; r < ZERO_REG; r++) begin
      inc_s[r]       = sb_set && (sb_addr == ADDR_W'(r));
      dec_s[r]       = rf_we && (rf_w_addr == ADDR_W'(r)) && (count_r[r] != CNT_ZERO);
      count_nxt_s[r] = count_r[r];
      if (inc_s[r] && !dec_s[r]) begin
        if (count_r[r] == CNT_MAX) begin
          ovf_hit_s = 1'b1;
        end else begin
          count_nxt_s[r] = count_r[r] + CNT_ONE;
        end
      end else if (dec_s[r] && !inc_s[r]) begin
        count_nxt_s[r] = count_r[r] - CNT_ONE;
      end else begin
        count_nxt_s[r] = count_r[r];
      end
    end
  end

  // Counter and sticky overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ZERO_REG; r++) begin
        count_r[r] <= CNT_ZERO;
      end
      ovf_r <= 1'b0;
    end else begin
      for (int r = 0; r < ZERO_REG; r++) begin
        count_r[r] <= count_nxt_s[r];
      end
      ovf_r <= ovf_r | ovf_hit_s;
    end
  end

  // Full 32-entry view so any address indexes safely; R31 never has a count.
  always_comb begin
    for (int r = 0; r < ZERO_REG; r++) begin
      count_view_s[r] = count_r[r];
    end
    count_view_s[ZERO_REG] = CNT_ZERO;
  end

  assign ra_cnt_s = count_view_s[ra_addr];
  assign rb_cnt_s = count_view_s[rb_addr];

  // The final outstanding write arriving this cycle is served by the bypass.
  always_comb begin
    ra_busy = 1'b0;
    rb_busy = 1'b0;
    if (is_zero_reg(ra_addr) || (ra_cnt_s == CNT_ZERO)) begin
      ra_busy = 1'b0;
    end else if (BYPASS && (ra_cnt_s == CNT_ONE) && addr_hit(rf_we, rf_w_addr, ra_addr)) begin
      ra_busy = 1'b0;
    end else begin
      ra_busy = 1'b1;
    end
    if (is_zero_reg(rb_addr) || (rb_cnt_s == CNT_ZERO)) begin
      rb_busy = 1'b0;
    end else if (BYPASS && (rb_cnt_s == CNT_ONE) && addr_hit(rf_we, rf_w_addr, rb_addr)) begin
      rb_busy = 1'b0;
    end else begin
      rb_busy = 1'b1;
    end
  end

  assign sb_overflow = ovf_r;

endmodule

// File: rtl/regfile.sv
// Beta register file top: R0-R30 storage, two combinational read ports
// with optional write bypass, and the pending-write scoreboard.
module regfile
  import regfile_pkg::*;
#(
  parameter bit BYPASS  = 1'b1,
  parameter int SB_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_busy,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_busy,
  input  logic [ADDR_W-1:0] rf_w_addr,
  input  logic [DATA_W-1:0] rf_w_data,
  input  logic              rf_we,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              sb_overflow
);

  logic [DATA_W-1:0] mem_r      [0:ZERO_REG-1];
  logic [DATA_W-1:0] mem_view_s [0:NUM_REGS-1];

  // Storage; writes aimed at R31 match no entry and fall away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ZERO_REG; r++) begin
        mem_r[r] <= DATA_ZERO;
      end
    end else begin
      for (int r = 0; r < ZERO_REG; r++) begin
        if (rf_we && (rf_w_addr == ADDR_W'(r))) begin
          mem_r[r] <= rf_w_data;
        end
      end
    end
  end

  // Full-range view with R31 tied to zero.
  always_comb begin
    for (int r = 0; r < ZERO_REG; r++) begin
      mem_view_s[r] = mem_r[r];
    end
    mem_view_s[ZERO_REG] = DATA_ZERO;
  end

  // Read muxes: zero register, then same-cycle bypass, then stored value.
  always_comb begin
    ra_data = DATA_ZERO;
    rb_data = DATA_ZERO;
    if (is_zero_reg(ra_addr)) begin
      ra_data = DATA_ZERO;
    end else if (BYPASS && addr_hit(rf_we, rf_w_addr, ra_addr)) begin
      ra_data = rf_w_data;
    end else begin
      ra_data = mem_view_s[ra_addr];
    end
    if (is_zero_reg(rb_addr)) begin
      rb_data = DATA_ZERO;
    end else if (BYPASS && addr_hit(rf_we, rf_w_addr, rb_addr)) begin
      rb_data = rf_w_data;
    end else begin
      rb_data = mem_view_s[rb_addr];
    end
  end

  rf_scoreboard #(
    .BYPASS  (BYPASS),
    .SB_BITS (SB_BITS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra_addr     (ra_addr),
    .rb_addr     (rb_addr),
    .rf_w_addr   (rf_w_addr),
    .rf_we       (rf_we),
    .sb_set      (sb_set),
    .sb_addr     (sb_addr),
    .ra_busy     (ra_busy),
    .rb_busy     (rb_busy),
    .sb_overflow (sb_overflow)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile (BYPASS=1, SB_BITS=2): each step drives one
// cycle of stimulus, queues the expected read-side view, then compares it.
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra_addr;
  logic [31:0] ra_data;
  logic        ra_busy;
  logic [4:0]  rb_addr;
  logic [31:0] rb_data;
  logic        rb_busy;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic        rf_we;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        sb_overflow;

  int checks_cnt;
  int errors_cnt;

  typedef struct {
    string       tag;
    logic [31:0] ra_data;
    logic        ra_busy;
    logic [31:0] rb_data;
    logic        rb_busy;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  regfile #(.BYPASS(1'b1), .SB_BITS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra_addr     (ra_addr),
    .ra_data     (ra_data),
    .ra_busy     (ra_busy),
    .rb_addr     (rb_addr),
    .rb_data     (rb_data),
    .rb_busy     (rb_busy),
    .rf_w_addr   (rf_w_addr),
    .rf_w_data   (rf_w_data),
    .rf_we       (rf_we),
    .sb_set      (sb_set),
    .sb_addr     (sb_addr),
    .sb_overflow (sb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = exp_q.pop_front();
    check_eq({e.tag, ".ra_data"}, ra_data, e.ra_data);
    check_eq({e.tag, ".ra_busy"}, {31'd0, ra_busy}, {31'd0, e.ra_busy});
    check_eq({e.tag, ".rb_data"}, rb_data, e.rb_data);
    check_eq({e.tag, ".rb_busy"}, {31'd0, rb_busy}, {31'd0, e.rb_busy});
    check_eq({e.tag, ".ovf"}, {31'd0, sb_overflow}, {31'd0, e.ovf});
  endtask

  // One cycle: drive between edges, queue expectation, compare before the next edge.
  task automatic step(input string tag, input logic rst_lvl,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic set, input logic [4:0] sa,
                      input logic [31:0] ea, input logic eab,
                      input logic [31:0] eb, input logic ebb, input logic eo);
    @(negedge clk);
    rst_n     = rst_lvl;
    ra_addr   = a;
    rb_addr   = b;
    rf_we     = we;
    rf_w_addr = wa;
    rf_w_data = wd;
    sb_set    = set;
    sb_addr   = sa;
    exp_q.push_back('{tag, ea, eab, eb, ebb, eo});
    #1;
    compare_head();
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0; ra_addr = 5'd0; rb_addr = 5'd0; rf_w_addr = 5'd0;
    rf_w_data = 32'd0; rf_we = 1'b0; sb_set = 1'b0; sb_addr = 5'd0;

    //    tag          rst  ra     rb     we    wa     wd            set   sa     ea            eab   eb            ebb   ovf
    step("rst_in",    1'b0, 5'd0,  5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    step("rst_r0_r5", 1'b1, 5'd0,  5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    step("rst_r31",   1'b1, 5'd31, 5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    step("byp_r3",    1'b1, 5'd3,  5'd3,  1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    step("stored_r3", 1'b1, 5'd3,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0);
    step("wr_r31",    1'b1, 5'd31, 5'd3,  1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    step("set_r31",   1'b1, 5'd31, 5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    step("r31_after", 1'b1, 5'd31, 5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    // R7 to depth 3, then overflow attempt
    step("set7_a",    1'b1, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    step("set7_b",    1'b1, 5'd7,  5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        1'b1, 32'h0,        1'b1, 1'b0);
    step("set7_c",    1'b1, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0);
    step("cnt7_3",    1'b1, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0);
    step("set7_ovf",  1'b1, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0);
    step("ovf_set",   1'b1, 5'd7,  5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b1);
    // Retire R7 three times; busy drops on the last one
    step("ret7_1",    1'b1, 5'd7,  5'd7,  1'b1, 5'd7,  32'h1,        1'b0, 5'd0,  32'h1,        1'b1, 32'h1,        1'b1, 1'b1);
    step("ret7_2",    1'b1, 5'd7,  5'd31, 1'b1, 5'd7,  32'h2,        1'b0, 5'd0,  32'h2,        1'b1, 32'h0,        1'b0, 1'b1);
    step("ret7_3",    1'b1, 5'd7,  5'd7,  1'b1, 5'd7,  32'h3,        1'b0, 5'd0,  32'h3,        1'b0, 32'h3,        1'b0, 1'b1);
    step("idle7",     1'b1, 5'd7,  5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h3,        1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    // R9: same-cycle set and write keeps count at 1
    step("set9",      1'b1, 5'd9,  5'd31, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1);
    step("cnt9_1",    1'b1, 5'd9,  5'd31, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b1);
    step("setwr9",    1'b1, 5'd9,  5'd31, 1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd9,  32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 1'b1);
    step("cnt9_kept", 1'b1, 5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);
    step("wr_other",  1'b1, 5'd9,  5'd3,  1'b1, 5'd3,  32'h0BADF00D, 1'b0, 5'd0,  32'hA5A5A5A5, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    step("pre_rst",   1'b1, 5'd9,  5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'hA5A5A5A5, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    // Asynchronous reset between edges clears everything at once
    step("mid_rst",   1'b0, 5'd9,  5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0);
    step("post_wr9",  1'b1, 5'd9,  5'd31, 1'b1, 5'd9,  32'h00000055, 1'b0, 5'd0,  32'h00000055, 1'b0, 32'h0,        1'b0, 1'b0);
    step("post_idle", 1'b1, 5'd9,  5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h00000055, 1'b0, 32'h0,        1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
